// File: rtl/ro_puf_eval_pkg.sv
// Shared types and constants for the ring-oscillator PUF evaluator.
package ro_puf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_CMP    = 2'd3
    } ro_state_t;

    // Cycles needed to flush stale data out of the 3-flop synchroniser.
    localparam int SETTLE_CYCLES = 3;

    localparam int DEF_N_CH  = 16;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_WIN_W = 16;

endpackage

// File: rtl/ro_puf_eval_if.sv
// Challenge/response bus between the PUF controller (master) and evaluator (slave).
interface ro_puf_eval_if
    import ro_puf_pkg::*;
#(
    parameter int SEL_W = $clog2(DEF_N_CH),
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W
) ();

    logic             start;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic [WIN_W-1:0] win_len;
    logic             busy;
    logic             done;
    logic             response;
    logic             tie;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    modport master (
        output start, sel_a, sel_b, win_len,
        input  busy, done, response, tie, cnt_a, cnt_b
    );

    modport slave (
        input  start, sel_a, sel_b, win_len,
        output busy, done, response, tie, cnt_a, cnt_b
    );

endinterface

// File: rtl/ro_puf_eval_edge_counter.sv
// One measurement channel: oscillator select, 3-flop synchroniser, rising-edge
// detect and saturating edge counter. count_next is the value after this edge.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int SEL_W = $clog2(N_CH),
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  osc_in,
    input  logic [SEL_W-1:0] sel,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count_next
);

    logic             line_s;
    logic             s1_r;
    logic             s2_r;
    logic             s3_r;
    logic             rise_s;
    logic [CNT_W-1:0] count_r;

    // Out-of-range selects read constant 0; only reachable when N_CH is not a power of two.
    if ((2 ** SEL_W) > N_CH) begin : g_sel_guard
        logic sel_ok_s;
        assign sel_ok_s = ({1'b0, sel} < (SEL_W + 1)'(N_CH));
        assign line_s   = sel_ok_s ? osc_in[sel] : 1'b0;
    end else begin : g_sel_full
        assign line_s = osc_in[sel];
    end

    // Synchroniser chain for the asynchronous oscillator line.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= line_s;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise_s = s2_r & ~s3_r;

    // Next count: clear wins, then a saturating increment on a detected edge.
    always_comb begin
        count_next = count_r;
        if (clear) begin
            count_next = {CNT_W{1'b0}};
        end else if (enable && rise_s && (count_r != {CNT_W{1'b1}})) begin
            count_next = count_r + CNT_W'(1);
        end else begin
            count_next = count_r;
        end
    end

    // Edge counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_next;
        end
    end

endmodule

// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF evaluator: selects two oscillators, counts their edges over
// a programmed window and reports which ran faster.
module ro_puf_eval
    import ro_puf_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int SEL_W = $clog2(N_CH),
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] osc_in,
    ro_puf_eval_if.slave    bus
);

    ro_state_t        state_r;
    ro_state_t        state_s;
    logic [SEL_W-1:0] sel_a_r;
    logic [SEL_W-1:0] sel_b_r;
    logic [WIN_W-1:0] win_len_r;
    logic [WIN_W-1:0] win_cnt_r;
    logic [1:0]       settle_cnt_r;
    logic             start_acc_s;
    logic             count_en_s;
    logic [CNT_W-1:0] cnt_a_next_s;
    logic [CNT_W-1:0] cnt_b_next_s;

    logic             busy_r;
    logic             done_r;
    logic             response_r;
    logic             tie_r;
    logic [CNT_W-1:0] cnt_a_r;
    logic [CNT_W-1:0] cnt_b_r;

    assign start_acc_s = (state_r == ST_IDLE) && bus.start;
    assign count_en_s  = (state_r == ST_COUNT);

    // Next-state logic for the evaluation sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_s = ST_SETTLE;
                else           state_s = ST_IDLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_r == 2'(SETTLE_CYCLES - 1))
                    state_s = (win_len_r == {WIN_W{1'b0}}) ? ST_CMP : ST_COUNT;
                else
                    state_s = ST_SETTLE;
            end
            ST_COUNT: begin
                if (win_cnt_r == WIN_W'(1)) state_s = ST_CMP;
                else                        state_s = ST_COUNT;
            end
            ST_CMP:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, settle/window timers and request latching.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= 2'd0;
            win_cnt_r    <= {WIN_W{1'b0}};
            sel_a_r      <= {SEL_W{1'b0}};
            sel_b_r      <= {SEL_W{1'b0}};
            win_len_r    <= {WIN_W{1'b0}};
        end else begin
            state_r      <= state_s;
            settle_cnt_r <= (state_r == ST_SETTLE) ? settle_cnt_r + 2'd1 : 2'd0;
            if (start_acc_s) begin
                sel_a_r   <= bus.sel_a;
                sel_b_r   <= bus.sel_b;
                win_len_r <= bus.win_len;
            end
            if ((state_r == ST_SETTLE) && (state_s == ST_COUNT))
                win_cnt_r <= win_len_r;
            else if (state_r == ST_COUNT)
                win_cnt_r <= win_cnt_r - WIN_W'(1);
        end
    end

    ro_edge_counter #(.N_CH(N_CH), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_cnt_a (
        .clk        (clk),
        .rst        (rst),
        .osc_in     (osc_in),
        .sel        (sel_a_r),
        .clear      (start_acc_s),
        .enable     (count_en_s),
        .count_next (cnt_a_next_s)
    );

    ro_edge_counter #(.N_CH(N_CH), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_cnt_b (
        .clk        (clk),
        .rst        (rst),
        .osc_in     (osc_in),
        .sel        (sel_b_r),
        .clear      (start_acc_s),
        .enable     (count_en_s),
        .count_next (cnt_b_next_s)
    );

    // Results are captured on entry to CMP from the counters' next values so the
    // final window edge is included and done lines up with the CMP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            response_r <= 1'b0;
            tie_r      <= 1'b0;
            cnt_a_r    <= {CNT_W{1'b0}};
            cnt_b_r    <= {CNT_W{1'b0}};
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_CMP);
            if (state_s == ST_CMP) begin
                response_r <= (cnt_a_next_s > cnt_b_next_s);
                tie_r      <= (cnt_a_next_s == cnt_b_next_s);
                cnt_a_r    <= cnt_a_next_s;
                cnt_b_r    <= cnt_b_next_s;
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.response = response_r;
    assign bus.tie      = tie_r;
    assign bus.cnt_a    = cnt_a_r;
    assign bus.cnt_b    = cnt_b_r;

endmodule

// File: tb/tb_ro_puf_eval.sv
// Directed bench for ro_puf_eval: expected results are queued at start and
// compared by a monitor when done pulses.
module tb_ro_puf_eval;
    import ro_puf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        osc0, osc3, osc5, osc7;
    logic [15:0] osc;

    always #5 clk = ~clk;

    initial begin osc0 = 1'b0; #13; forever #20 osc0 = ~osc0; end
    initial begin osc3 = 1'b0; #3;  forever #20 osc3 = ~osc3; end
    initial begin osc5 = 1'b0; #17; forever #20 osc5 = ~osc5; end
    initial begin osc7 = 1'b0; #7;  forever #30 osc7 = ~osc7; end

    assign osc = {8'b0, osc7, 1'b0, osc5, 1'b0, osc3, 2'b0, osc0};

    ro_puf_eval_if #(.SEL_W(4), .CNT_W(16), .WIN_W(16)) bus ();
    ro_puf_eval_if #(.SEL_W(4), .CNT_W(4),  .WIN_W(16)) bus2 ();

    ro_puf_eval #(.N_CH(16), .SEL_W(4), .CNT_W(16), .WIN_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .osc_in (osc),
        .bus    (bus)
    );

    ro_puf_eval #(.N_CH(12), .SEL_W(4), .CNT_W(4), .WIN_W(16)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .osc_in (osc[11:0]),
        .bus    (bus2)
    );

    typedef struct {
        int   exp_cyc;
        logic resp;
        logic tie;
        int   a_lo, a_hi, b_lo, b_hi;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
        n_checks++;
        assert ((obs >= 32'(lo)) && (obs <= 32'(hi))) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Scoreboard monitor: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            n_checks++;
            assert (sb_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_done: observed done=1 at cycle %0d expected no done", cyc);
            end
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(mon_e.exp_cyc));
                check("response", {31'b0, bus.response}, {31'b0, mon_e.resp});
                check("tie", {31'b0, bus.tie}, {31'b0, mon_e.tie});
                check_rng("cnt_a", {16'b0, bus.cnt_a}, mon_e.a_lo, mon_e.a_hi);
                check_rng("cnt_b", {16'b0, bus.cnt_b}, mon_e.b_lo, mon_e.b_hi);
            end
        end
    end

    task automatic issue(input logic [3:0] sa, input logic [3:0] sb, input int wl,
                         input logic resp, input logic tie,
                         input int alo, input int ahi, input int blo, input int bhi);
        exp_t e;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.sel_a   = sa;
        bus.sel_b   = sb;
        bus.win_len = 16'(wl);
        e.exp_cyc = cyc + wl + 4;
        e.resp = resp; e.tie = tie;
        e.a_lo = alo; e.a_hi = ahi; e.b_lo = blo; e.b_hi = bhi;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", {31'b0, bus.busy}, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && bus.done !== 1'b1; i++) @(negedge clk);
        check("done_seen", {31'b0, bus.done}, 32'd1);
        if (bus.done !== 1'b1) sb_q.delete();
        @(negedge clk);
        check("busy_after_done", {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        int base;
        int t0;
        rst = 1'b1;
        bus.start = 1'b0;  bus.sel_a = 4'd0;  bus.sel_b = 4'd0;  bus.win_len = 16'd0;
        bus2.start = 1'b0; bus2.sel_a = 4'd0; bus2.sel_b = 4'd0; bus2.win_len = 16'd0;
        repeat (5) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_response", {31'b0, bus.response}, 32'd0);
        check("rst_tie", {31'b0, bus.tie}, 32'd0);
        check("rst_cnt_a", {16'b0, bus.cnt_a}, 32'd0);
        check("rst_cnt_b", {16'b0, bus.cnt_b}, 32'd0);

        // start while reset is held must not launch an evaluation
        bus.start = 1'b1; bus.win_len = 16'd10;
        repeat (3) @(negedge clk);
        check("rst_start_busy", {31'b0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", {31'b0, bus.busy}, 32'd0);

        issue(4'd3, 4'd7, 96, 1'b1, 1'b0, 23, 25, 15, 17);
        wait_done(120);
        issue(4'd7, 4'd3, 96, 1'b0, 1'b0, 15, 17, 23, 25);
        wait_done(120);
        issue(4'd5, 4'd5, 96, 1'b0, 1'b1, 23, 25, 23, 25);
        wait_done(120);
        issue(4'd3, 4'd7, 0, 1'b0, 1'b1, 0, 0, 0, 0);
        wait_done(20);

        // saturation on the narrow-counter instance; sel_b=13 is beyond N_CH=12
        @(negedge clk);
        bus2.start = 1'b1; bus2.sel_a = 4'd0; bus2.sel_b = 4'd13; bus2.win_len = 16'd200;
        t0 = cyc;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int i = 0; i < 260 && bus2.done !== 1'b1; i++) @(negedge clk);
        check("sat_done_seen", {31'b0, bus2.done}, 32'd1);
        check("sat_done_cycle", 32'(cyc), 32'(t0 + 204));
        check("sat_cnt_a", {28'b0, bus2.cnt_a}, 32'd15);
        check("sat_cnt_b", {28'b0, bus2.cnt_b}, 32'd0);
        check("sat_response", {31'b0, bus2.response}, 32'd1);
        check("sat_tie", {31'b0, bus2.tie}, 32'd0);

        // reset mid-run discards the evaluation
        @(negedge clk);
        bus.start = 1'b1; bus.sel_a = 4'd3; bus.sel_b = 4'd7; bus.win_len = 16'd96;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        base = done_cnt;
        repeat (120) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - base), 32'd0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_response", {31'b0, bus.response}, 32'd0);
        check("abort_tie", {31'b0, bus.tie}, 32'd0);
        check("abort_cnt_a", {16'b0, bus.cnt_a}, 32'd0);

        // fresh run with an ignored start pulse while busy
        base = done_cnt;
        issue(4'd3, 4'd7, 96, 1'b1, 1'b0, 23, 25, 15, 17);
        repeat (10) @(negedge clk);
        bus.start = 1'b1; bus.sel_a = 4'd7; bus.sel_b = 4'd3; bus.win_len = 16'd0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(120);
        repeat (10) @(negedge clk);
        check("busy_start_ignored", 32'(done_cnt - base), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_puf_eval.md
# ro_puf_eval

Parametrised ring-oscillator PUF evaluator: two N-to-1 input selectors pick a pair of oscillator lines by challenge, synchronise them into the system clock, count rising edges over a programmable window and compare the counts to produce one response bit. It sits between the oscillator array and the challenge/response controller. It replaces the fixed 16:1 combinational selection stage with a registered, handshaked measurement path.

## Interface
- `N_CH`, 16, number of oscillator inputs (≥2)
- `SEL_W`, `$clog2(N_CH)`, challenge select width
- `CNT_W`, 16, edge counter width
- `WIN_W`, 16, window length width
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset, synchronous, active-high
- `osc_in`  in  N_CH  raw oscillator lines, asynchronous to clk
- `start`  in  1  request evaluation; sampled only in IDLE
- `sel_a`  in  SEL_W  first oscillator index
- `sel_b`  in  SEL_W  second oscillator index
- `win_len`  in  WIN_W  count window in clk cycles
- `busy`  out  1  high from cycle after accepted start until done
- `done`  out  1  one-cycle pulse, results valid
- `response`  out  1  1 iff cnt_a > cnt_b
- `tie`  out  1  1 iff cnt_a == cnt_b
- `cnt_a`, `cnt_b`  out  CNT_W  final edge counts

## Operation
- FSM states: IDLE, SETTLE, COUNT, CMP.
- IDLE: on `start`=1, latch `sel_a`, `sel_b`, `win_len`, clear both counters, go to SETTLE. `start` is ignored in every other state.
- SETTLE: lasts exactly 3 cycles and flushes the synchroniser. Edges are not counted. Then go to COUNT. If latched `win_len`=0, go directly to CMP instead.
- COUNT: lasts latched `win_len` cycles. On each cycle with a detected rising edge, the channel counter increments. Counters saturate at 2^CNT_W−1 and never wrap.
- CMP: one cycle. Register `response`, `tie`, `cnt_a`, `cnt_b`, pulse `done`, return to IDLE.
- Per channel, the selected line is indexed by the latched select and passes through 3 flops (s1, s2, s3). A rising edge is s2 & ~s3.
- Select ≥ N_CH: the channel reads constant 0.
- `sel_a`==`sel_b` is legal. Counts are equal, so `tie`=1 and `response`=0.
- Result outputs hold their values until the next CMP. They are not cleared by a new `start`.
- `rst` in any state returns the FSM to IDLE next cycle and clears counters, synchronisers and all outputs. Any in-flight evaluation is discarded with no `done` pulse.

## Timing
- Reset values: `busy`=0, `done`=0, `response`=0, `tie`=0, `cnt_a`=0, `cnt_b`=0, FSM in IDLE.
- `start` accepted at cycle T gives the following sequence:
  - `busy`=1 from T+1.
  - SETTLE runs T+1..T+3.
  - COUNT runs T+4..T+3+W.
  - CMP and `done` occur at T+4+W.
  - `busy`=0 from T+5+W.
- Latency is start-to-done = W+4 cycles; for W=0 it is 4.
- The next `start` is accepted at T+5+W at the earliest. Back-to-back evaluations have a throughput of one per W+5 cycles.
- Edge detection resolves at most one edge per 2 clk cycles. Oscillator frequency above clk/2 is out of spec and gives undercount.

## Structure
- Package `ro_puf_pkg` holds:
  - the FSM state enum `ro_state_t`;
  - the constant `SETTLE_CYCLES`=3;
  - default parameter constants.
- Sub-module `ro_edge_counter` (params N_CH, SEL_W, CNT_W):
  - contains the select index, the 3-flop synchroniser, the edge detect and the saturating counter;
  - has `clear` and `enable` inputs;
  - is instantiated twice, once for A and once for B.
- The top level owns the FSM, the window counter, the latching and the compare.

## Test plan
- Reset with `osc_in` toggling → all outputs 0, `busy`=0. Then `start` with `rst` held → no `busy`.
- ch3 period 4 clk, ch7 period 6 clk, sel_a=3, sel_b=7, win_len=96 → `done` at start+100, cnt_a=24±1, cnt_b=16±1, `response`=1, `tie`=0.
- Same stimulus with sel_a=7, sel_b=3 → `response`=0. With sel_a=sel_b=5 → `tie`=1, `response`=0.
- win_len=0 → `done` at start+4, cnt_a=cnt_b=0, `tie`=1.
- CNT_W=4, ch0 period 4, win_len=200 → cnt_a saturates at 15, no wrap.
- `rst` at start+20 of a win_len=96 run → no `done`, outputs 0. A fresh `start` afterwards completes normally. A `start` pulse while `busy` is ignored.
